// File: rtl/enemy_inflate_ctrl.sv
// Per-enemy inflation tracker: counts pumps, deflates on frame timeouts,
// pops at MAX_LEVEL and reports death after the pop sprite is shown.
module enemy_inflate_ctrl #(
   parameter int MAX_LEVEL      = 4,
   parameter int DEFLATE_FRAMES = 60,
   parameter int POP_FRAMES     = 30
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Frame_tick,
   input  logic       Increment_pumped,
   input  logic       Respawn,
   output logic [2:0] Inflate_level,
   output logic       Enemy_frozen,
   output logic       Enemy_popped,
   output logic       Enemy_dead
);

   typedef enum logic [1:0] {
      IDLE,
      INFLATED,
      POPPING,
      DEAD
   } state_t;

   localparam logic [2:0] MAX_L   = 3'(MAX_LEVEL);
   localparam logic [7:0] DEF_END = 8'(DEFLATE_FRAMES - 1);
   localparam logic [7:0] POP_END = 8'(POP_FRAMES - 1);

   state_t     state_q, state_d;
   logic [2:0] level_q, level_d;
   logic [7:0] dtmr_q, dtmr_d;
   logic [7:0] ptmr_q, ptmr_d;
   logic       frozen_q, frozen_d;
   logic       popped_q, popped_d;
   logic       dead_q, dead_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= IDLE;
         level_q  <= '0;
         dtmr_q   <= '0;
         ptmr_q   <= '0;
         frozen_q <= 1'b0;
         popped_q <= 1'b0;
         dead_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         dtmr_q   <= dtmr_d;
         ptmr_q   <= ptmr_d;
         frozen_q <= frozen_d;
         popped_q <= popped_d;
         dead_q   <= dead_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      dtmr_d   = dtmr_q;
      ptmr_d   = ptmr_q;
      popped_d = 1'b0;
      if (Respawn) begin
         state_d = IDLE;
         level_d = '0;
         dtmr_d  = '0;
         ptmr_d  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Increment_pumped) begin
                  state_d = INFLATED;
                  level_d = 3'd1;
                  dtmr_d  = '0;
               end
            end
            INFLATED: begin
               // a pump wins over a coincident tick and restarts the timeout
               if (Increment_pumped) begin
                  level_d = level_q + 3'd1;
                  dtmr_d  = '0;
                  if (level_q + 3'd1 == MAX_L) begin
                     state_d  = POPPING;
                     popped_d = 1'b1;
                     ptmr_d   = '0;
                  end
               end else if (Frame_tick) begin
                  if (dtmr_q == DEF_END) begin
                     level_d = level_q - 3'd1;
                     dtmr_d  = '0;
                     if (level_q == 3'd1)
                        state_d = IDLE;
                  end else begin
                     dtmr_d = dtmr_q + 8'd1;
                  end
               end
            end
            POPPING: begin
               if (Frame_tick) begin
                  if (ptmr_q == POP_END) begin
                     state_d = DEAD;
                     ptmr_d  = '0;
                  end else begin
                     ptmr_d = ptmr_q + 8'd1;
                  end
               end
            end
            DEAD: begin
               state_d = DEAD;
            end
            default: begin
               state_d = IDLE;
               level_d = '0;
            end
         endcase
      end
      frozen_d = (state_d == INFLATED) || (state_d == POPPING);
      dead_d   = (state_d == DEAD);
   end

   assign Inflate_level = level_q;
   assign Enemy_frozen  = frozen_q;
   assign Enemy_popped  = popped_q;
   assign Enemy_dead    = dead_q;

endmodule
